// File: rtl/dlx_pkg.sv
// Shared constants and types for the DLX instruction-fetch front end.
// Holds reset address, default widths and the prefetch FSM encoding.
package dlx_pkg;

   localparam int DLX_DATA_WIDTH      = 32;
   localparam int DLX_INST_ADDR_WIDTH = 20;
   localparam int PC_STEP             = 4;

   localparam logic [DLX_INST_ADDR_WIDTH-1:0] PC_INITIAL_ADDRESS = 20'h40000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_t;

   // Pointer width for a power-of-two ring; never narrower than one bit.
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// Slot ring for the prefetch unit: per-slot {pc, instr, filled} plus the
// issue/fill/read pointers. Head slot contents are presented combinationally.
module fetch_slot_ring
   import dlx_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  issue_en,
   input  logic [ADDR_WIDTH-1:0] issue_pc,
   input  logic                  fill_en,
   input  logic [DATA_WIDTH-1:0] fill_instr,
   input  logic                  consume_en,
   output logic                  head_filled,
   output logic [ADDR_WIDTH-1:0] head_pc,
   output logic [DATA_WIDTH-1:0] head_instr
);

   localparam int PTR_W = ptr_bits(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] issue_ptr_reg;
   logic [PTR_W-1:0] fill_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;

   logic                  filled_vec [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_vec     [DEPTH];
   logic [DATA_WIDTH-1:0] instr_vec  [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         issue_ptr_reg <= '0;
         fill_ptr_reg  <= '0;
         rd_ptr_reg    <= '0;
      end else begin
         if (issue_en) begin
            issue_ptr_reg <= issue_ptr_reg + PTR_ONE;
         end
         if (fill_en) begin
            fill_ptr_reg <= fill_ptr_reg + PTR_ONE;
         end
         if (consume_en) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         localparam logic [PTR_W-1:0] SLOT_IDX = PTR_W'(gi);

         logic                  slot_filled_reg;
         logic [ADDR_WIDTH-1:0] slot_pc_reg;
         logic [DATA_WIDTH-1:0] slot_instr_reg;

         always_ff @(posedge clk) begin
            if (rst || clear) begin
               slot_filled_reg <= 1'b0;
               slot_pc_reg     <= '0;
               slot_instr_reg  <= '0;
            end else begin
               if (issue_en && (issue_ptr_reg == SLOT_IDX)) begin
                  slot_pc_reg <= issue_pc;
               end
               if (fill_en && (fill_ptr_reg == SLOT_IDX)) begin
                  slot_instr_reg <= fill_instr;
               end
               // A slot being reserved or consumed is never the fill target.
               if (fill_en && (fill_ptr_reg == SLOT_IDX)) begin
                  slot_filled_reg <= 1'b1;
               end else if ((issue_en && (issue_ptr_reg == SLOT_IDX)) ||
                            (consume_en && (rd_ptr_reg == SLOT_IDX))) begin
                  slot_filled_reg <= 1'b0;
               end
            end
         end

         assign filled_vec[gi] = slot_filled_reg;
         assign pc_vec[gi]     = slot_pc_reg;
         assign instr_vec[gi]  = slot_instr_reg;
      end
   endgenerate

   assign head_filled = filled_vec[rd_ptr_reg];
   assign head_pc     = pc_vec[rd_ptr_reg];
   assign head_instr  = instr_vec[rd_ptr_reg];

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches into a slot ring,
// presents the head to decode, and drains in-flight responses after redirect.
module prefetch_unit
   import dlx_pkg::*;
#(
   parameter int                         DATA_WIDTH         = DLX_DATA_WIDTH,
   parameter int                         INST_ADDR_WIDTH    = DLX_INST_ADDR_WIDTH,
   parameter int                         DEPTH              = 4,
   parameter logic [INST_ADDR_WIDTH-1:0] PC_INITIAL_ADDRESS = dlx_pkg::PC_INITIAL_ADDRESS,
   parameter int                         PC_INCREMENT       = PC_STEP
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       instr_rd_en,
   output logic [INST_ADDR_WIDTH-1:0] instr_addr,
   input  logic                       instr_gnt,
   input  logic                       instr_rvalid,
   input  logic [DATA_WIDTH-1:0]      instruction,
   input  logic                       stall_in,
   input  logic                       select_new_pc_in,
   input  logic [INST_ADDR_WIDTH-1:0] new_pc_in,
   output logic                       if_valid_out,
   output logic [DATA_WIDTH-1:0]      if_instruction_out,
   output logic [INST_ADDR_WIDTH-1:0] if_pc_out,
   output logic                       protocol_err_out
);

   localparam int PTR_W = ptr_bits(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]           CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
   localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP_W = INST_ADDR_WIDTH'(PC_INCREMENT);

   fetch_state_t               state_reg;
   logic [INST_ADDR_WIDTH-1:0] fetch_pc_reg;
   logic [CNT_W-1:0]           used_reg;
   logic [CNT_W-1:0]           outstanding_reg;
   logic [CNT_W-1:0]           drop_cnt_reg;
   logic                       protocol_err_reg;

   logic                       rd_en;
   logic                       issue;
   logic                       fill;
   logic                       discard;
   logic                       unexpected;
   logic                       head_valid;
   logic                       consume;
   logic [CNT_W-1:0]           drop_next;

   logic                       head_filled;
   logic [INST_ADDR_WIDTH-1:0] head_pc;
   logic [DATA_WIDTH-1:0]      head_instr;

   always_comb begin
      rd_en      = !rst && (state_reg == ST_RUN) && (used_reg < CNT_FULL) && !select_new_pc_in;
      issue      = rd_en && instr_gnt;
      fill       = !rst && instr_rvalid && (state_reg == ST_RUN) && (outstanding_reg != '0);
      discard    = !rst && instr_rvalid && (state_reg == ST_DRAIN);
      unexpected = !rst && instr_rvalid && (state_reg == ST_RUN) && (outstanding_reg == '0);
      head_valid = !rst && head_filled && (used_reg != '0);
      consume    = head_valid && !stall_in && !select_new_pc_in;

      // Responses still owed after this cycle: in RUN they become stale on a
      // redirect, in DRAIN they are the remaining discards.
      if (state_reg == ST_RUN) begin
         drop_next = outstanding_reg - (fill ? CNT_ONE : '0);
      end else begin
         drop_next = drop_cnt_reg - (discard ? CNT_ONE : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_RUN;
         fetch_pc_reg     <= PC_INITIAL_ADDRESS;
         used_reg         <= '0;
         outstanding_reg  <= '0;
         drop_cnt_reg     <= '0;
         protocol_err_reg <= 1'b0;
      end else begin
         if (unexpected) begin
            protocol_err_reg <= 1'b1;
         end

         if (select_new_pc_in) begin
            fetch_pc_reg    <= new_pc_in;
            used_reg        <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= drop_next;
            state_reg       <= (drop_next != '0) ? ST_DRAIN : ST_RUN;
         end else begin
            case (state_reg)
               ST_RUN: begin
                  if (issue) begin
                     fetch_pc_reg <= fetch_pc_reg + PC_STEP_W;
                  end
                  outstanding_reg <= outstanding_reg + (issue ? CNT_ONE : '0)
                                                     - (fill ? CNT_ONE : '0);
                  used_reg        <= used_reg + (issue ? CNT_ONE : '0)
                                              - (consume ? CNT_ONE : '0);
               end
               ST_DRAIN: begin
                  drop_cnt_reg <= drop_next;
                  if (drop_next == '0) begin
                     state_reg <= ST_RUN;
                  end
               end
               default: begin
                  state_reg <= ST_RUN;
               end
            endcase
         end
      end
   end

   fetch_slot_ring #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (INST_ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ring (
      .clk         (clk),
      .rst         (rst),
      .clear       (select_new_pc_in),
      .issue_en    (issue),
      .issue_pc    (fetch_pc_reg),
      .fill_en     (fill),
      .fill_instr  (instruction),
      .consume_en  (consume),
      .head_filled (head_filled),
      .head_pc     (head_pc),
      .head_instr  (head_instr)
   );

   assign instr_rd_en        = rd_en;
   assign instr_addr         = fetch_pc_reg;
   assign if_valid_out       = head_valid;
   assign if_instruction_out = head_valid ? head_instr : '0;
   assign if_pc_out          = head_valid ? head_pc : '0;
   assign protocol_err_out   = protocol_err_reg;

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: an in-order memory with variable latency drives the
// DUT while an abstract stream model predicts fetches, head data and errors.
module tb_prefetch_unit;

   localparam int AW    = 20;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_rd_en;
   logic [AW-1:0] instr_addr;
   logic          instr_gnt = 1'b0;
   logic          instr_rvalid = 1'b0;
   logic [DW-1:0] instruction = '0;
   logic          stall_in = 1'b0;
   logic          select_new_pc_in = 1'b0;
   logic [AW-1:0] new_pc_in = '0;
   logic          if_valid_out;
   logic [DW-1:0] if_instruction_out;
   logic [AW-1:0] if_pc_out;
   logic          protocol_err_out;

   always #5 clk = ~clk;

   prefetch_unit #(
      .DATA_WIDTH (DW), .INST_ADDR_WIDTH (AW), .DEPTH (DEPTH),
      .PC_INITIAL_ADDRESS (20'h40000), .PC_INCREMENT (4)
   ) dut (
      .clk (clk), .rst (rst),
      .instr_rd_en (instr_rd_en), .instr_addr (instr_addr), .instr_gnt (instr_gnt),
      .instr_rvalid (instr_rvalid), .instruction (instruction),
      .stall_in (stall_in), .select_new_pc_in (select_new_pc_in), .new_pc_in (new_pc_in),
      .if_valid_out (if_valid_out), .if_instruction_out (if_instruction_out),
      .if_pc_out (if_pc_out), .protocol_err_out (protocol_err_out)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Memory: pending requests in issue order with the cycle they may answer.
   logic [AW-1:0] mem_addr_q[$];
   int            mem_due_q[$];

   // Stream model: next fetch address, next expected head, slot accounting.
   logic [AW-1:0] m_issue_pc, m_head_pc;
   int            m_used, m_fresh_out, m_avail, m_stale;
   logic          m_err;

   logic          obs_rd_en, obs_valid, obs_err;
   logic [AW-1:0] obs_addr, obs_pc;
   logic [DW-1:0] obs_instr;
   logic          exp_rd_en, exp_valid, exp_err;
   logic [AW-1:0] exp_addr, exp_pc;
   logic [DW-1:0] exp_instr;
   bit            last_rv, last_issue;

   function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
      return {12'hC3A, a} ^ 32'h5A00_0000;
   endfunction

   task automatic model_reset();
      m_issue_pc  = 20'h40000;
      m_head_pc   = 20'h40000;
      m_used      = 0;
      m_fresh_out = 0;
      m_avail     = 0;
      m_stale     = 0;
      m_err       = 1'b0;
   endtask

   // One clock: drive inputs, sample outputs, predict, then advance the model.
   task automatic cycle(input bit r, input bit g, input bit s, input bit sel,
                        input logic [AW-1:0] npc, input bit spur, input int lat);
      bit rv, fill_m, issue, consume;
      @(negedge clk);
      rst = r; instr_gnt = g; stall_in = s; select_new_pc_in = sel; new_pc_in = npc;
      rv = 1'b0;
      instruction = $urandom;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         rv = 1'b1;
         instruction = inst_of(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else if (spur) begin
         rv = 1'b1;
         instruction = 32'hBADB_AD00;
      end
      instr_rvalid = rv;
      #1;
      obs_rd_en = instr_rd_en; obs_addr = instr_addr; obs_valid = if_valid_out;
      obs_pc = if_pc_out; obs_instr = if_instruction_out; obs_err = protocol_err_out;
      exp_rd_en = !r && !sel && (m_used < DEPTH) && (m_stale == 0);
      exp_addr  = m_issue_pc;
      exp_valid = !r && (m_avail > 0);
      exp_pc    = exp_valid ? m_head_pc : '0;
      exp_instr = exp_valid ? inst_of(m_head_pc) : '0;
      exp_err   = m_err;
      issue   = (obs_rd_en === 1'b1) && g;
      consume = exp_valid && !s && !sel;
      if (issue) begin
         mem_addr_q.push_back(obs_addr);
         mem_due_q.push_back(cyc + 1 + lat);
      end
      last_rv = rv; last_issue = issue;
      if (r) begin
         model_reset();
      end else begin
         fill_m = 1'b0;
         if (rv) begin
            if (m_stale > 0) m_stale--;
            else if (m_fresh_out > 0) begin m_fresh_out--; fill_m = 1'b1; end
            else m_err = 1'b1;
         end
         if (consume) begin m_avail--; m_used--; m_head_pc = m_head_pc + 20'd4; end
         if (issue) begin m_used++; m_fresh_out++; m_issue_pc = m_issue_pc + 20'd4; end
         if (fill_m) m_avail++;
         if (sel) begin
            m_stale += m_fresh_out; m_fresh_out = 0; m_used = 0; m_avail = 0;
            m_issue_pc = npc; m_head_pc = npc;
         end
      end
      cyc++;
   endtask

   // Redirect, then idle until every old response has come back.
   task automatic settle(input logic [AW-1:0] target);
      cycle(0, 0, 0, 1, target, 0, 0);
      for (int i = 0; i < 40 && (mem_addr_q.size() > 0 || m_stale > 0); i++)
         cycle(0, 0, 0, 0, '0, 0, 0);
      tests++;
      if (mem_addr_q.size() > 0 || m_stale > 0) begin
         fails++; $display("FAIL settle_timeout pending=%0d required=0", mem_addr_q.size());
      end
   endtask

   task automatic test_reset();
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 1, 20'h12340, 0, 0);
         tests++; if (obs_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=0", obs_rd_en); end
         tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", obs_valid); end
         tests++; if (obs_pc !== '0) begin fails++; $display("FAIL reset_pc got=%h exp=0", obs_pc); end
         tests++; if (obs_instr !== '0) begin fails++; $display("FAIL reset_instr got=%h exp=0", obs_instr); end
         tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", obs_err); end
      end
      $display("[TB] reset: 3 cycles held");
   endtask

   task automatic test_sequential();
      int start, first_rv, first_valid;
      start = cyc; first_rv = -1; first_valid = -1;
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, 0, 0, '0, 0, 0);
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL seq_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         if (exp_rd_en && obs_rd_en) begin
            tests++; if (obs_addr !== exp_addr) begin fails++; $display("FAIL seq_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end
         end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL seq_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_pc !== exp_pc) begin fails++; $display("FAIL seq_pc cyc=%0d got=%h exp=%h", cyc, obs_pc, exp_pc); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL seq_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
         if (last_rv && first_rv < 0) first_rv = cyc - 1;
         if (obs_valid === 1'b1 && first_valid < 0) first_valid = cyc - 1;
      end
      tests++;
      if (first_valid != start + 2 || first_rv != start + 1) begin
         fails++; $display("FAIL seq_latency first_rv=%0d first_valid=%0d required %0d/%0d", first_rv - start, first_valid - start, 1, 2);
      end
      $display("[TB] sequential: first response cycle %0d, first valid cycle %0d", first_rv - start, first_valid - start);
   endtask

   task automatic test_stall();
      int n_issue, n_cons;
      settle(20'h40200);
      n_issue = 0; n_cons = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 1, 0, '0, 0, 0);
         n_issue += int'(last_issue);
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL stall_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
      end
      tests++; if (n_issue != DEPTH) begin fails++; $display("FAIL stall_issue_count got=%0d exp=%0d", n_issue, DEPTH); end
      tests++; if (obs_rd_en !== 1'b0) begin fails++; $display("FAIL stall_full_rd_en got=%b exp=0", obs_rd_en); end
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 0, 0, '0, 0, 0);
         if (obs_valid === 1'b1) n_cons++;
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL release_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL release_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_pc !== exp_pc) begin fails++; $display("FAIL release_pc cyc=%0d got=%h exp=%h", cyc, obs_pc, exp_pc); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL release_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
      end
      tests++; if (n_cons < DEPTH) begin fails++; $display("FAIL release_consumed got=%0d exp>=%0d", n_cons, DEPTH); end
      $display("[TB] stall: %0d issued while stalled, %0d delivered after release", n_issue, n_cons);
   endtask

   task automatic test_redirect_drain();
      logic [AW-1:0] first_addr;
      bit seen;
      settle(20'h40000);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, '0, 0, 8);
      cycle(0, 1, 0, 1, 20'h40100, 0, 0);
      seen = 1'b0; first_addr = '0;
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, 0, 0, '0, 0, 0);
         if (last_issue && !seen) begin seen = 1'b1; first_addr = obs_addr; end
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL drain_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL drain_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_pc !== exp_pc) begin fails++; $display("FAIL drain_pc cyc=%0d got=%h exp=%h", cyc, obs_pc, exp_pc); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL drain_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
      end
      tests++; if (!seen || first_addr !== 20'h40100) begin fails++; $display("FAIL drain_first_addr got=%h exp=40100", first_addr); end
      $display("[TB] redirect_drain: first post-redirect request %h", first_addr);
   endtask

   task automatic test_redirect_coincident();
      int n_zero;
      bit seen;
      settle(20'h40000);
      cycle(0, 1, 1, 0, '0, 0, 1);
      cycle(0, 1, 1, 0, '0, 0, 5);
      cycle(0, 0, 0, 1, 20'h40300, 0, 0);
      tests++; if (last_rv !== 1'b1) begin fails++; $display("FAIL coinc_rvalid got=%b exp=1", last_rv); end
      n_zero = 0; seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 0, 0, '0, 0, 0);
         if (!seen && obs_rd_en === 1'b0) n_zero++;
         if (obs_rd_en === 1'b1) seen = 1'b1;
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL coinc_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL coinc_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL coinc_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
      end
      tests++; if (n_zero != 5) begin fails++; $display("FAIL coinc_drain_cycles got=%0d exp=5", n_zero); end
      $display("[TB] redirect_coincident: %0d idle cycles before issue", n_zero);
   endtask

   task automatic test_pc_wrap();
      logic [AW-1:0] a0, a1;
      int n;
      settle(20'hFFFFC);
      n = 0; a0 = '0; a1 = '0;
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, 0, 0, '0, 0, 0);
         if (last_issue) begin
            if (n == 0) a0 = obs_addr;
            if (n == 1) a1 = obs_addr;
            n++;
         end
         tests++; if (obs_pc !== exp_pc) begin fails++; $display("FAIL wrap_pc cyc=%0d got=%h exp=%h", cyc, obs_pc, exp_pc); end
      end
      tests++; if (a0 !== 20'hFFFFC) begin fails++; $display("FAIL wrap_addr0 got=%h exp=ffffc", a0); end
      tests++; if (a1 !== 20'h00000) begin fails++; $display("FAIL wrap_addr1 got=%h exp=00000", a1); end
      $display("[TB] pc_wrap: %h -> %h", a0, a1);
   endtask

   task automatic test_protocol_err();
      settle(20'h40500);
      cycle(0, 1, 1, 0, '0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, '0, 0, 0);
      cycle(0, 0, 1, 0, '0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 1, 0, '0, 0, 0);
         tests++; if (obs_err !== exp_err) begin fails++; $display("FAIL perr_err cyc=%0d got=%b exp=%b", cyc, obs_err, exp_err); end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL perr_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL perr_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
      end
      tests++; if (obs_err !== 1'b1) begin fails++; $display("FAIL perr_sticky got=%b exp=1", obs_err); end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, '0, 0, 0);
      $display("[TB] protocol_err: err=%b", obs_err);
   endtask

   task automatic test_mid_reset();
      settle(20'h40000);
      cycle(0, 1, 1, 0, '0, 0, 4);
      cycle(0, 1, 1, 0, '0, 0, 4);
      cycle(1, 0, 0, 0, '0, 0, 0);
      tests++; if (obs_rd_en !== 1'b0 || obs_valid !== 1'b0) begin fails++; $display("FAIL midrst_outputs rd_en=%b valid=%b exp=0/0", obs_rd_en, obs_valid); end
      for (int i = 0; i < 20 && mem_addr_q.size() > 0; i++) begin
         cycle(0, 0, 1, 0, '0, 0, 0);
         tests++; if (obs_err !== exp_err) begin fails++; $display("FAIL midrst_err cyc=%0d got=%b exp=%b", cyc, obs_err, exp_err); end
      end
      cycle(0, 0, 1, 0, '0, 0, 0);
      tests++; if (obs_err !== 1'b1) begin fails++; $display("FAIL midrst_late_resp got=%b exp=1", obs_err); end
      cycle(1, 0, 0, 0, '0, 0, 0);
      cycle(0, 0, 0, 0, '0, 0, 0);
      tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL midrst_clear got=%b exp=0", obs_err); end
      $display("[TB] mid_reset: error flag raised and cleared");
   endtask

   task automatic test_random();
      logic [AW-1:0] npc;
      bit g, s, sel;
      for (int i = 0; i < 1500; i++) begin
         g   = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 3) == 0);
         sel = ($urandom_range(0, 40) == 0);
         npc = AW'($urandom);
         npc[1:0] = 2'b00;
         cycle(0, g, s, sel, npc, 0, $urandom_range(0, 3));
         tests++; if (obs_rd_en !== exp_rd_en) begin fails++; $display("FAIL rnd_rd_en cyc=%0d got=%b exp=%b", cyc, obs_rd_en, exp_rd_en); end
         if (exp_rd_en && obs_rd_en) begin
            tests++; if (obs_addr !== exp_addr) begin fails++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_addr); end
         end
         tests++; if (obs_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
         tests++; if (obs_pc !== exp_pc) begin fails++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, obs_pc, exp_pc); end
         tests++; if (obs_instr !== exp_instr) begin fails++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", cyc, obs_instr, exp_instr); end
         tests++; if (obs_err !== exp_err) begin fails++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, obs_err, exp_err); end
      end
      $display("[TB] random: 1500 cycles");
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_drain();
      test_redirect_coincident();
      test_pc_wrap();
      test_protocol_err();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DATA_WIDTH  32  instruction width
  INST_ADDR_WIDTH  20  instruction address width
  DEPTH  4  slot count, power of two, >=2
  PC_INITIAL_ADDRESS  20'h40000  fetch address after reset
  PC_INCREMENT  4  sequential address step
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous, active-high reset
  instr_rd_en  out  1  memory request valid
  instr_addr  out  INST_ADDR_WIDTH  request address
  instr_gnt  in  1  memory accepts request this cycle
  instr_rvalid  in  1  in-order response valid
  instruction  in  DATA_WIDTH  response data
  stall_in  in  1  decode not accepting
  select_new_pc_in  in  1  redirect from execute
  new_pc_in  in  INST_ADDR_WIDTH  redirect target
  if_valid_out  out  1  head slot holds instruction
  if_instruction_out  out  DATA_WIDTH  head instruction
  if_pc_out  out  INST_ADDR_WIDTH  address of head instruction
  protocol_err_out  out  1  sticky: unexpected response seen
REQ-003 SHALL use the single clock clk and synchronous active-high reset rst (fixed decision).

Function
REQ-004 SHALL hold a DEPTH-entry slot ring: per slot {pc, instr, filled}; pointers issue_ptr, fill_ptr, rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-005 SHALL keep used = slots reserved, not yet consumed (0..DEPTH); issue only when used < DEPTH.
REQ-006 SHALL assert instr_rd_en combinationally when state RUN, used < DEPTH, select_new_pc_in=0; instr_addr = fetch_pc.
REQ-007 SHALL, on instr_rd_en && instr_gnt: reserve slot[issue_ptr] with pc=fetch_pc, filled=0; issue_ptr++; fetch_pc += PC_INCREMENT (wraps at 2^INST_ADDR_WIDTH).
REQ-008 SHALL, on instr_rvalid in RUN with outstanding>0: slot[fill_ptr].instr=instruction, filled=1, fill_ptr++; if_valid_out rises next cycle (1-cycle response-to-output latency).
REQ-009 SHALL drive if_valid_out = slot[rd_ptr].filled && used>0; if_instruction_out/if_pc_out from slot[rd_ptr] (zero when invalid).
REQ-010 SHALL consume head when if_valid_out && !stall_in: clear filled, rd_ptr++, used--; simultaneous issue and consume leave used unchanged.
REQ-011 SHALL implement FSM states RUN, DRAIN.
REQ-012 SHALL, on select_new_pc_in (any state): fetch_pc=new_pc_in; all slots cleared; used=0; pointers realigned to 0; no issue that cycle; consume suppressed.
REQ-013 SHALL compute drop_cnt = outstanding minus (1 if instr_rvalid same cycle); drop_cnt>0 -> DRAIN, else RUN.
REQ-014 SHALL, in DRAIN: issue nothing; each instr_rvalid decrements drop_cnt, data discarded; drop_cnt reaching 0 -> RUN next cycle.
REQ-015 SHALL, on redirect while in DRAIN: update fetch_pc, keep drop_cnt (minus same-cycle rvalid), stay DRAIN unless it reaches 0.
REQ-016 SHALL, on instr_rvalid with zero outstanding and drop_cnt=0: ignore data, set protocol_err_out until rst.
REQ-017 SHALL size outstanding and drop_cnt at log2(DEPTH)+1 bits; overflow impossible by REQ-005.

Reset
REQ-018 SHALL, on rst: fetch_pc=PC_INITIAL_ADDRESS; pointers, used, outstanding, drop_cnt=0; all filled=0; state RUN; protocol_err_out=0.
REQ-019 SHALL, during rst: instr_rd_en=0, if_valid_out=0, if_instruction_out=0, if_pc_out=0; rst dominates select_new_pc_in; responses after mid-operation rst count as REQ-016 errors.

Structure
REQ-020 SHALL place PC_INITIAL_ADDRESS, width localparams and the RUN/DRAIN encoding in shared package dlx_pkg.
REQ-021 SHALL implement the slot array and pointers in one sub-module fetch_slot_ring; counters and FSM stay in prefetch_unit.

Verification
REQ-022 Reset then instr_gnt=1, 1-cycle response -> addresses 0x40000, 0x40004, 0x40008...; if_valid_out first at cycle 3 after rst drops, if_pc_out=0x40000.
REQ-023 stall_in=1 held, instr_gnt=1 -> exactly DEPTH (4) requests issued, instr_rd_en then 0; release stall -> 4 instructions in order, issuing resumes.
REQ-024 3 outstanding, redirect new_pc_in=0x40100 -> DRAIN; 3 responses discarded; next request 0x40100; no stale if_valid_out.
REQ-025 Redirect coincident with one rvalid, 2 outstanding -> drop_cnt=1; one discard, then RUN.
REQ-026 rvalid with nothing outstanding -> protocol_err_out=1, stays 1 until rst, if_valid_out unaffected.
REQ-027 fetch_pc=0xFFFFC, step 4 -> next request address 0x00000 (wrap).
